// File: rtl/stepper_pkg.sv
// Shared constants, types and helpers for the stepper_bank peripheral.
package stepper_pkg;

  localparam int CH_STRIDE = 16;

  // Byte offsets within a channel's register block
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_STEPS  = 4'h4;
  localparam logic [3:0] OFF_PERIOD = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  // CTRL bits
  localparam int CTRL_START = 0;
  localparam int CTRL_DIR   = 1;
  localparam int CTRL_ABORT = 2;

  // STATUS bits
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_REM_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW
  } chan_state_t;

  // One-cycle command pulses from the register file to a channel
  typedef struct packed {
    logic start;
    logic abort;
    logic clr_done;
  } chan_cmd_t;

  // Byte-lane merge of a bus write into an existing 32-bit value
  function automatic logic [31:0] wmerge(input logic [31:0] old_v,
                                         input logic [31:0] wdata,
                                         input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/stepper_bank_channel.sv
// One step/dir channel: shadow registers plus the IDLE/SETUP/HIGH/LOW sequencer.
module stepper_bank_channel
  import stepper_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int DIV_WIDTH   = 16,
  parameter int PULSE_WIDTH = 4,
  parameter int DIR_SETUP   = 8
) (
  input  logic                 clk_in,
  input  logic                 reset_n_in,
  input  chan_cmd_t            cmd,
  input  logic [CNT_WIDTH-1:0] steps,
  input  logic [DIV_WIDTH-1:0] period,
  input  logic                 dir,
  output logic                 step_out,
  output logic                 dir_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [CNT_WIDTH-1:0] remaining
);

  localparam logic [DIV_WIDTH-1:0] MIN_PER    = DIV_WIDTH'(2 * PULSE_WIDTH);
  localparam logic [DIV_WIDTH-1:0] SETUP_LAST = DIV_WIDTH'(DIR_SETUP - 1);
  localparam logic [DIV_WIDTH-1:0] PW_LAST    = DIV_WIDTH'(PULSE_WIDTH - 1);

  chan_state_t          state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;   // setup timer, then cycles since rising edge
  logic [DIV_WIDTH-1:0] per_q, per_d;   // latched, already clamped period
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic                 dir_q, dir_d;
  logic                 done_q, done_d;
  logic [DIV_WIDTH-1:0] eff_per;

  // Short periods are stretched so the low phase is at least as long as the high phase
  assign eff_per = (period < MIN_PER) ? MIN_PER : period;

  // Next-state logic; done set is applied after the W1C clear so a set wins
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    done_d  = done_q;
    if (cmd.clr_done) done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: if (cmd.start) begin
        if (steps == '0) begin
          done_d = 1'b1;
          rem_d  = '0;
        end else begin
          done_d  = 1'b0;
          rem_d   = steps;
          per_d   = eff_per;
          dir_d   = dir;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          rem_d   = rem_q - CNT_WIDTH'(1);
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      ST_HIGH: begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
        if (cnt_q == PW_LAST) state_d = ST_LOW;
      end
      ST_LOW: begin
        if (cnt_q == per_q - DIV_WIDTH'(1)) begin
          cnt_d = '0;
          if (rem_q != '0) begin
            rem_d   = rem_q - CNT_WIDTH'(1);
            state_d = ST_HIGH;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides any progress made this cycle and freezes the count
    if (cmd.abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      rem_d   = rem_q;
      done_d  = 1'b1;
    end
  end

  // Channel state registers
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign step_out  = (state_q == ST_HIGH);
  assign busy_out  = (state_q != ST_IDLE);
  assign dir_out   = dir_q;
  assign done_out  = done_q;
  assign remaining = rem_q;

endmodule

// File: rtl/stepper_bank.sv
// N-channel step/dir generator on the picorv32 native bus: decode, register file, read mux.
module stepper_bank
  import stepper_pkg::*;
#(
  parameter int          CHANNELS    = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0100,
  parameter int          CNT_WIDTH   = 32,
  parameter int          DIV_WIDTH   = 16,
  parameter int          PULSE_WIDTH = 4,
  parameter int          DIR_SETUP   = 8
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic                mem_valid,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wstrb,
  output logic [31:0]         mem_rdata,
  output logic                mem_ready,
  output logic [CHANNELS-1:0] step_out,
  output logic [CHANNELS-1:0] dir_out,
  output logic [CHANNELS-1:0] busy_out
);

  localparam int          SW          = $clog2(CHANNELS + 1);
  localparam int          CIW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [31:0] BLOCK_BYTES = 32'(CH_STRIDE * (CHANNELS + 1));

  logic [31:0]   offset;
  logic [SW-1:0] slot;
  logic [CIW-1:0] ch;
  logic [3:0]    reg_off;
  logic          in_blk, acc, wr, is_ch, is_map;
  logic          unused_addr;

  logic [CHANNELS-1:0][CNT_WIDTH-1:0] steps_q, steps_d;
  logic [CHANNELS-1:0][DIV_WIDTH-1:0] period_q, period_d;
  logic [CHANNELS-1:0]                dir_q, dir_d;
  chan_cmd_t [CHANNELS-1:0]           cmd_q, cmd_d;
  logic [CHANNELS-1:0]                done_w;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] rem_w;

  logic        ready_q, ready_d;
  logic        hold_q, hold_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_val;

  assign offset      = mem_addr - BASE_ADDR;
  assign in_blk      = (mem_addr >= BASE_ADDR) && (offset < BLOCK_BYTES);
  assign slot        = offset[4 +: SW];
  assign ch          = slot[CIW-1:0];
  assign reg_off     = {offset[3:2], 2'b00};
  assign is_ch       = slot < SW'(CHANNELS);
  assign is_map      = slot == SW'(CHANNELS);
  assign wr          = |mem_wstrb;
  assign unused_addr = ^{offset[31:4+SW], offset[1:0]};
  // hold_q blocks re-acceptance until mem_valid drops, so a held request is acked once
  assign acc         = mem_valid && in_blk && !hold_q;

  // Register writes and command pulses; pulses are registered so a channel sees
  // DIR/STEPS/PERIOD already updated when START arrives
  always_comb begin
    steps_d  = steps_q;
    period_d = period_q;
    dir_d    = dir_q;
    cmd_d    = '0;
    if (acc && wr && is_ch) begin
      case (reg_off)
        OFF_CTRL: if (mem_wstrb[0]) begin
          dir_d[ch]       = mem_wdata[CTRL_DIR];
          cmd_d[ch].abort = mem_wdata[CTRL_ABORT];
          cmd_d[ch].start = mem_wdata[CTRL_START] & ~mem_wdata[CTRL_ABORT];
        end
        OFF_STEPS:  steps_d[ch]  = CNT_WIDTH'(wmerge(32'(steps_q[ch]), mem_wdata, mem_wstrb));
        OFF_PERIOD: period_d[ch] = DIV_WIDTH'(wmerge(32'(period_q[ch]), mem_wdata, mem_wstrb));
        OFF_STATUS: if (mem_wstrb[0] && mem_wdata[STAT_DONE]) cmd_d[ch].clr_done = 1'b1;
        default: ;
      endcase
    end
  end

  // Read mux; unmapped locations inside the block read as zero
  always_comb begin
    rd_val = '0;
    if (is_ch) begin
      case (reg_off)
        OFF_CTRL:   rd_val[CTRL_DIR] = dir_q[ch];
        OFF_STEPS:  rd_val = 32'(steps_q[ch]);
        OFF_PERIOD: rd_val = 32'(period_q[ch]);
        OFF_STATUS: begin
          rd_val[STAT_BUSY]       = busy_out[ch];
          rd_val[STAT_DONE]       = done_w[ch];
          rd_val[31:STAT_REM_LSB] = 24'(rem_w[ch]);
        end
        default: ;
      endcase
    end else if (is_map && reg_off == OFF_CTRL) begin
      rd_val = 32'(busy_out);
    end
  end

  // Bus handshake: one registered ack per request, rdata zero outside the ack cycle
  always_comb begin
    ready_d = acc;
    rdata_d = (acc && !wr) ? rd_val : '0;
    hold_d  = acc ? 1'b1 : (mem_valid ? hold_q : 1'b0);
  end

  // Register file and bus state
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      steps_q  <= '0;
      period_q <= '0;
      dir_q    <= '0;
      cmd_q    <= '0;
      ready_q  <= 1'b0;
      hold_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      steps_q  <= steps_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      cmd_q    <= cmd_d;
      ready_q  <= ready_d;
      hold_q   <= hold_d;
      rdata_q  <= rdata_d;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    stepper_bank_channel #(
      .CNT_WIDTH  (CNT_WIDTH),
      .DIV_WIDTH  (DIV_WIDTH),
      .PULSE_WIDTH(PULSE_WIDTH),
      .DIR_SETUP  (DIR_SETUP)
    ) u_ch (
      .clk_in    (clk_in),
      .reset_n_in(reset_n_in),
      .cmd       (cmd_q[g]),
      .steps     (steps_q[g]),
      .period    (period_q[g]),
      .dir       (dir_q[g]),
      .step_out  (step_out[g]),
      .dir_out   (dir_out[g]),
      .busy_out  (busy_out[g]),
      .done_out  (done_w[g]),
      .remaining (rem_w[g])
    );
  end

endmodule

// File: tb/tb_stepper_bank.sv
// Scoreboard bench for stepper_bank: bus reads checked from a queue, step/busy
// waveforms checked cycle by cycle against a closed-form model of each run.
module tb_stepper_bank;

  localparam int          CH   = 12;
  localparam logic [31:0] BASE = 32'h1000_0100;
  localparam int          DS   = 8;
  localparam int          PW   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_valid = 1'b0;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_wstrb = '0;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic [CH-1:0] step_out, dir_out, busy_out;

  stepper_bank #(.CHANNELS(CH), .BASE_ADDR(BASE), .CNT_WIDTH(32), .DIV_WIDTH(16),
                 .PULSE_WIDTH(PW), .DIR_SETUP(DS)) dut (
    .clk_in(clk), .reset_n_in(rst_n), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .step_out(step_out), .dir_out(dir_out), .busy_out(busy_out));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, rdy_cnt = 0;

  // Model: register contents, status, and the current run per channel
  logic [31:0] m_steps[CH], m_period[CH], m_rem[CH];
  bit          m_done[CH], m_dir[CH];
  bit          r_pend[CH], r_act[CH], r_abort[CH], r_dir[CH];
  int          r_anchor[CH], r_n[CH], r_eff[CH], r_dl[CH];
  bit          xq_chk[$];
  logic [31:0] xq_val[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_steps[c] = 0; m_period[c] = 0; m_rem[c] = 0; m_done[c] = 0; m_dir[c] = 0;
      r_pend[c] = 0; r_act[c] = 0; r_abort[c] = 0;
    end
    xq_chk.delete(); xq_val.delete();
  endtask

  // Monitor: pops expected read data on every ack, checks waveforms each cycle
  task automatic monitor();
    bit prev_rdy = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin prev_rdy = 0; continue; end
      if (mem_ready) begin
        rdy_cnt++;
        check("single_ack", {31'b0, prev_rdy}, 32'd0);
        if (xq_chk.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got ready with no request pending (cycle %0d)", cyc);
        end else begin
          bit c; logic [31:0] v;
          c = xq_chk.pop_front(); v = xq_val.pop_front();
          if (c) check("rdata", mem_rdata, v);
        end
      end else begin
        check("rdata_idle", mem_rdata, 32'd0);
      end
      prev_rdy = mem_ready;
      for (int c = 0; c < CH; c++) begin
        if (r_pend[c]) begin
          if (busy_out[c]) begin
            r_pend[c] = 0; r_act[c] = 1; r_anchor[c] = cyc;
            check($sformatf("dir[%0d]", c), {31'b0, dir_out[c]}, {31'b0, r_dir[c]});
          end else if (cyc > r_dl[c]) begin
            checks++; errors++; r_pend[c] = 0;
            $display("FAIL start_timeout[%0d]: got busy 0 expected 1", c);
          end
        end else if (r_act[c]) begin
          int t, k, n, e;
          t = cyc - r_anchor[c]; n = r_n[c]; e = r_eff[c];
          if (r_abort[c]) begin
            if (!busy_out[c]) begin
              check($sformatf("abort_step[%0d]", c), {31'b0, step_out[c]}, 32'd0);
              k = (t - 1 >= DS) ? (t - 1 - DS) / e + 1 : 0;
              if (k > n) k = n;
              m_rem[c] = n - k; m_done[c] = 1; r_act[c] = 0; r_abort[c] = 0;
            end else if (cyc > r_dl[c]) begin
              checks++; errors++; r_act[c] = 0; r_abort[c] = 0;
              $display("FAIL abort_timeout[%0d]: got busy 1 expected 0", c);
            end
          end else begin
            bit eb, es;
            eb = t < DS + n * e;
            es = eb && t >= DS && ((t - DS) % e) < PW;
            check($sformatf("step[%0d]", c), {31'b0, step_out[c]}, {31'b0, es});
            check($sformatf("busy[%0d]", c), {31'b0, busy_out[c]}, {31'b0, eb});
            if (!eb) begin r_act[c] = 0; m_done[c] = 1; m_rem[c] = 0; end
          end
        end else begin
          check($sformatf("idle[%0d]", c), {30'b0, step_out[c], busy_out[c]}, 32'd0);
        end
      end
    end
  endtask

  function automatic logic [31:0] ra(input int c, input int off);
    return BASE + 32'(16 * c + off);
  endfunction

  task automatic bus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                     input bit chk, input logic [31:0] exp);
    int n = 0;
    xq_chk.push_back(chk); xq_val.push_back(exp);
    @(posedge clk); #1;
    mem_valid = 1; mem_addr = addr; mem_wdata = data; mem_wstrb = strb;
    do begin @(negedge clk); n++; end while (!mem_ready && n < 16);
    if (!mem_ready) begin
      checks++; errors++;
      $display("FAIL bus_timeout: got no ready for addr %h", addr);
      if (xq_chk.size() > 0) begin void'(xq_chk.pop_back()); void'(xq_val.pop_back()); end
    end
    @(posedge clk); #1;
    mem_valid = 0; mem_wstrb = 0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    bus(addr, 32'd0, 4'h0, 1, exp);
  endtask

  // Register write that also updates the model per byte lane
  task automatic setreg(input int c, input int off, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) begin
      if (off == 4) m_steps[c][8*b +: 8] = d[8*b +: 8];
      if (off == 8 && b < 2) m_period[c][8*b +: 8] = d[8*b +: 8];
    end
    if (off == 12 && s[0] && d[1]) m_done[c] = 0;
    bus(ra(c, off), d, s, 0, 32'd0);
  endtask

  task automatic start(input int c, input bit dir);
    m_dir[c] = dir;
    if (!(r_pend[c] || r_act[c])) begin
      if (m_steps[c] == 0) begin
        m_done[c] = 1; m_rem[c] = 0;
      end else begin
        m_done[c] = 0; r_pend[c] = 1; r_n[c] = m_steps[c]; r_dir[c] = dir;
        r_eff[c] = (m_period[c] < 2 * PW) ? 2 * PW : m_period[c];
        r_dl[c] = cyc + 12;
      end
    end
    bus(ra(c, 0), {30'b0, dir, 1'b1}, 4'h1, 0, 32'd0);
  endtask

  task automatic abort_ch(input int c);
    m_dir[c] = 0;
    if (r_act[c]) begin r_abort[c] = 1; r_dl[c] = cyc + 12; end
    bus(ra(c, 0), 32'h4, 4'h1, 0, 32'd0);
  endtask

  task automatic wait_idle(input int c);
    int n = 0;
    while ((r_pend[c] || r_act[c]) && n < 20000) begin @(negedge clk); n++; end
    if (r_pend[c] || r_act[c]) begin
      checks++; errors++; r_pend[c] = 0; r_act[c] = 0;
      $display("FAIL idle_timeout[%0d]: got busy expected idle", c);
    end
  endtask

  task automatic wait_rises(input int c, input int k);
    int n = 0;
    while (!(r_act[c] && cyc >= r_anchor[c] + DS + (k - 1) * r_eff[c] + 2) && n < 20000) begin
      @(negedge clk); n++;
    end
  endtask

  function automatic logic [31:0] status_exp(input int c);
    return {m_rem[c][23:0], 6'b0, m_done[c], 1'b0};
  endfunction

  initial begin
    int base_rdy;
    logic [31:0] bm;
    model_reset();
    fork monitor(); join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_step", 32'(step_out), 32'd0);
    check("rst_dir", 32'(dir_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    @(negedge clk); rst_n = 1;
    rd(ra(0, 4), 0); rd(ra(0, 8), 0); rd(ra(0, 12), 0); rd(ra(CH, 0), 0);

    // Basic run
    setreg(0, 4, 5, 4'hF); setreg(0, 8, 20, 4'hF);
    start(0, 1); wait_idle(0);
    rd(ra(0, 12), status_exp(0)); rd(ra(0, 0), 32'h2);
    setreg(0, 12, 2, 4'hF); rd(ra(0, 12), status_exp(0));

    // Zero steps and period clamp
    setreg(1, 4, 0, 4'hF); start(1, 0); repeat (4) @(negedge clk);
    rd(ra(1, 12), status_exp(1));
    setreg(1, 4, 3, 4'hF); setreg(1, 8, 2, 4'hF); start(1, 1); wait_idle(1);
    rd(ra(1, 12), status_exp(1));

    // Abort after ten pulses
    setreg(5, 4, 1000, 4'hF); setreg(5, 8, 50, 4'hF); start(5, 1);
    wait_rises(5, 10); abort_ch(5); wait_idle(5);
    rd(ra(5, 12), status_exp(5));

    // Concurrency and shadowing
    setreg(0, 4, 8, 4'hF); setreg(0, 8, 20, 4'hF);
    setreg(11, 4, 6, 4'hF); setreg(11, 8, 30, 4'hF);
    start(0, 0); start(11, 1);
    repeat (6) @(negedge clk);
    bm = 0;
    for (int c = 0; c < CH; c++) bm[c] = r_act[c];
    rd(ra(CH, 0), bm);
    setreg(0, 8, 40, 4'hF);
    wait_idle(0); wait_idle(11);
    start(0, 1); wait_idle(0);
    rd(ra(0, 8), m_period[0]);

    // Bus corner cases
    setreg(2, 4, 32'hAABBCCDD, 4'hF); setreg(2, 4, 32'h11223344, 4'h1);
    rd(ra(2, 4), m_steps[2]);
    rd(ra(CH, 4), 0);
    bus(ra(CH, 0), 32'hFFFF_FFFF, 4'hF, 0, 0); rd(ra(CH, 0), 0);
    base_rdy = rdy_cnt;
    @(posedge clk); #1; mem_valid = 1; mem_addr = BASE - 4; mem_wstrb = 0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1; mem_valid = 0;
    repeat (3) @(negedge clk);
    check("out_of_block_acks", 32'(rdy_cnt - base_rdy), 32'd0);
    base_rdy = rdy_cnt;
    xq_chk.push_back(1); xq_val.push_back(m_steps[2]);
    @(posedge clk); #1; mem_valid = 1; mem_addr = ra(2, 4);
    repeat (4) @(negedge clk);
    @(posedge clk); #1; mem_valid = 0;
    repeat (3) @(negedge clk);
    check("held_valid_acks", 32'(rdy_cnt - base_rdy), 32'd1);

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++) begin
        int c;
        c = $urandom_range(0, CH - 1);
        setreg(c, 4, $urandom_range(0, 6), 4'hF);
        setreg(c, 8, $urandom_range(0, 30), 4'hF);
        start(c, 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      if ($urandom_range(0, 2) == 0)
        for (int c = 0; c < CH; c++) if (r_act[c]) begin abort_ch(c); break; end
      for (int c = 0; c < CH; c++) wait_idle(c);
      for (int c = 0; c < CH; c++) if (m_done[c]) begin
        rd(ra(c, 12), status_exp(c));
        setreg(c, 12, 2, 4'h1);
      end
    end

    // Reset in the middle of a run
    setreg(0, 4, 100, 4'hF); setreg(0, 8, 20, 4'hF); start(0, 1);
    wait_rises(0, 3);
    @(posedge clk); #2; rst_n = 0; #1;
    check("arst_step", 32'(step_out), 32'd0);
    check("arst_busy", 32'(busy_out), 32'd0);
    check("arst_dir", 32'(dir_out), 32'd0);
    check("arst_ready", {31'b0, mem_ready}, 32'd0);
    model_reset();
    repeat (2) @(negedge clk); rst_n = 1;
    rd(ra(0, 4), 0); rd(ra(0, 8), 0); rd(ra(0, 12), 0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
